// File: rtl/csr_unit_timer_pkg.sv
// Shared CSR addresses, field masks, exception codes and read/write select indices.
package csr_unit_timer_pkg;

  // CSR addresses
  localparam logic [13:0] CsrCrmd   = 14'h000;
  localparam logic [13:0] CsrPrmd   = 14'h001;
  localparam logic [13:0] CsrEcfg   = 14'h004;
  localparam logic [13:0] CsrEstat  = 14'h005;
  localparam logic [13:0] CsrEra    = 14'h006;
  localparam logic [13:0] CsrBadv   = 14'h007;
  localparam logic [13:0] CsrEentry = 14'h00c;
  localparam logic [13:0] CsrSave0  = 14'h030;
  localparam logic [13:0] CsrSave1  = 14'h031;
  localparam logic [13:0] CsrSave2  = 14'h032;
  localparam logic [13:0] CsrSave3  = 14'h033;
  localparam logic [13:0] CsrTid    = 14'h040;
  localparam logic [13:0] CsrTcfg   = 14'h041;
  localparam logic [13:0] CsrTval   = 14'h042;
  localparam logic [13:0] CsrTiclr  = 14'h044;

  // Software-writable bits per register
  localparam logic [31:0] CrmdWmask   = 32'h0000_01ff;  // PLV, IE, DA, PG, DATF, DATM
  localparam logic [31:0] PrmdWmask   = 32'h0000_0007;  // PPLV, PIE
  localparam logic [31:0] EcfgWmask   = 32'h0000_1bff;  // LIE, bit 10 hard 0
  localparam logic [31:0] EentryWmask = 32'hffff_ffc0;  // VA[31:6]

  // CRMD field positions
  localparam int unsigned CrmdIeBit = 2;
  localparam int unsigned CrmdDaBit = 3;

  // Exception codes that update BADV
  localparam logic [5:0] EcodeAdef = 6'h08;
  localparam logic [5:0] EcodeAle  = 6'h09;

  // One-hot select index for the decoded CSR address
  typedef enum logic [3:0] {
    SelCrmd, SelPrmd, SelEcfg, SelEstat, SelEra, SelBadv, SelEentry,
    SelSave0, SelSave1, SelSave2, SelSave3, SelTid, SelTcfg, SelTval, SelTiclr
  } csr_sel_e;

  localparam int unsigned NumSel = 15;

  function automatic logic [31:0] masked_wr(input logic [31:0] old_val,
                                            input logic [31:0] wmask,
                                            input logic [31:0] wvalue);
    return (wmask & wvalue) | (~wmask & old_val);
  endfunction

endpackage

// File: rtl/csr_unit_timer_timer.sv
// Countdown timer: TCFG/TVAL registers, one-shot/periodic reload and the TICLR clear strobe.
module csr_unit_timer_timer
  import csr_unit_timer_pkg::*;
#(
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tcfg_we,
  input  logic               ticlr_we,
  input  logic [TIMER_W-1:0] wmask,
  input  logic [TIMER_W-1:0] wvalue,
  output logic [31:0]        tcfg_rvalue,
  output logic [31:0]        tval_rvalue,
  output logic               timer_fire,
  output logic               timer_clear
);

  localparam logic [TIMER_W-1:0] TvalOne = {{(TIMER_W-1){1'b0}}, 1'b1};

  logic [TIMER_W-1:0] tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;
  logic [TIMER_W-1:0] tcfg_new;

  assign tcfg_new = (wmask & wvalue) | (~wmask & tcfg_q);

  // Next-state: a TCFG write reloads without decrementing; otherwise count down while enabled
  always_comb begin
    tcfg_d     = tcfg_q;
    tval_d     = tval_q;
    timer_fire = 1'b0;
    if (tcfg_we) begin
      tcfg_d = tcfg_new;
      tval_d = {tcfg_new[TIMER_W-1:2], 2'b00};
    end else if (tcfg_q[0]) begin
      if (tval_q != '0) begin
        tval_d     = tval_q - TvalOne;
        timer_fire = (tval_q == TvalOne);
      end else if (tcfg_q[1]) begin
        // periodic reload; InitVal of 0 keeps reloading 0 and never fires
        tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
      end
    end
  end

  // Timer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcfg_q <= '0;
      tval_q <= '0;
    end else begin
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
    end
  end

  assign tcfg_rvalue = 32'(tcfg_q);
  assign tval_rvalue = 32'(tval_q);
  assign timer_clear = ticlr_we & wmask[0] & wvalue[0];

endmodule

// File: rtl/csr_unit_timer.sv
// LA32 CSR file: exception state, interrupt status/enable, scratch registers and the timer.
module csr_unit_timer
  import csr_unit_timer_pkg::*;
#(
  parameter int unsigned TIMER_W   = 32,
  parameter int unsigned HWI_NUM   = 8,
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_re,
  input  logic [13:0]        csr_num,
  output logic [31:0]        csr_rvalue,
  input  logic               csr_we,
  input  logic [31:0]        csr_wmask,
  input  logic [31:0]        csr_wvalue,
  input  logic [HWI_NUM-1:0] hw_int_in,
  input  logic               ipi_int_in,
  input  logic               wb_ex,
  input  logic [5:0]         wb_ecode,
  input  logic [8:0]         wb_esubcode,
  input  logic [31:0]        wb_pc,
  input  logic [31:0]        wb_vaddr,
  input  logic               ertn_flush,
  output logic [31:0]        ex_entry,
  output logic [31:0]        ertn_pc,
  output logic               has_int
);

  logic [NumSel-1:0] sel;
  logic              wr_en;

  logic [31:0] crmd_q, crmd_d;
  logic [31:0] prmd_q, prmd_d;
  logic [31:0] ecfg_q, ecfg_d;
  logic [1:0]  is_sw_q, is_sw_d;
  logic [7:0]  is_hw_q, hw_ext;
  logic        is_ipi_q;
  logic        is_timer_q, is_timer_d;
  logic [5:0]  ecode_q, ecode_d;
  logic [8:0]  esub_q, esub_d;
  logic [31:0] era_q, era_d;
  logic [31:0] badv_q, badv_d;
  logic [31:0] eentry_q, eentry_d;
  logic [31:0] save_q [4];
  logic [31:0] save_d [4];
  logic [31:0] tid_q, tid_d;

  logic [12:0] estat_is;
  logic [31:0] estat_rd;
  logic [31:0] tcfg_rd, tval_rd;
  logic        timer_fire, timer_clear;
  logic [31:0] rd_data [NumSel];

  // Exceptions and ertn take the cycle; a colliding CSR write is dropped
  assign wr_en = csr_we & ~wb_ex & ~ertn_flush;

  // Address decode to a one-hot select shared by reads and writes
  always_comb begin
    sel = '0;
    case (csr_num)
      CsrCrmd:   sel[SelCrmd]   = 1'b1;
      CsrPrmd:   sel[SelPrmd]   = 1'b1;
      CsrEcfg:   sel[SelEcfg]   = 1'b1;
      CsrEstat:  sel[SelEstat]  = 1'b1;
      CsrEra:    sel[SelEra]    = 1'b1;
      CsrBadv:   sel[SelBadv]   = 1'b1;
      CsrEentry: sel[SelEentry] = 1'b1;
      CsrSave0:  sel[SelSave0]  = 1'b1;
      CsrSave1:  sel[SelSave1]  = 1'b1;
      CsrSave2:  sel[SelSave2]  = 1'b1;
      CsrSave3:  sel[SelSave3]  = 1'b1;
      CsrTid:    sel[SelTid]    = 1'b1;
      CsrTcfg:   sel[SelTcfg]   = 1'b1;
      CsrTval:   sel[SelTval]   = 1'b1;
      CsrTiclr:  sel[SelTiclr]  = 1'b1;
      default:   sel            = '0;
    endcase
  end

  csr_unit_timer_timer #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .tcfg_we     (wr_en & sel[SelTcfg]),
    .ticlr_we    (wr_en & sel[SelTiclr]),
    .wmask       (csr_wmask[TIMER_W-1:0]),
    .wvalue      (csr_wvalue[TIMER_W-1:0]),
    .tcfg_rvalue (tcfg_rd),
    .tval_rvalue (tval_rd),
    .timer_fire  (timer_fire),
    .timer_clear (timer_clear)
  );

  // Zero-extend the hardware interrupt lines onto IS[9:2]
  always_comb begin
    hw_ext                = '0;
    hw_ext[HWI_NUM-1:0]   = hw_int_in;
  end

  // A fire in the same cycle as a clear wins so no tick is lost
  assign is_timer_d = timer_fire | (is_timer_q & ~timer_clear);

  // Next-state for architectural CSRs: wb_ex > ertn_flush > csr write
  always_comb begin
    crmd_d   = crmd_q;
    prmd_d   = prmd_q;
    ecfg_d   = ecfg_q;
    is_sw_d  = is_sw_q;
    ecode_d  = ecode_q;
    esub_d   = esub_q;
    era_d    = era_q;
    badv_d   = badv_q;
    eentry_d = eentry_q;
    save_d   = save_q;
    tid_d    = tid_q;
    if (wb_ex) begin
      prmd_d      = {29'b0, crmd_q[CrmdIeBit], crmd_q[1:0]};
      crmd_d[2:0] = 3'b000;
      era_d       = wb_pc;
      ecode_d     = wb_ecode;
      esub_d      = wb_esubcode;
      if (wb_ecode == EcodeAdef || wb_ecode == EcodeAle) begin
        badv_d = wb_vaddr;
      end
    end else if (ertn_flush) begin
      crmd_d[2:0] = prmd_q[2:0];
    end else if (csr_we) begin
      if (sel[SelCrmd])   crmd_d   = masked_wr(crmd_q, csr_wmask & CrmdWmask, csr_wvalue);
      if (sel[SelPrmd])   prmd_d   = masked_wr(prmd_q, csr_wmask & PrmdWmask, csr_wvalue);
      if (sel[SelEcfg])   ecfg_d   = masked_wr(ecfg_q, csr_wmask & EcfgWmask, csr_wvalue);
      if (sel[SelEstat])  is_sw_d  = (csr_wmask[1:0] & csr_wvalue[1:0]) |
                                     (~csr_wmask[1:0] & is_sw_q);
      if (sel[SelEra])    era_d    = masked_wr(era_q, csr_wmask, csr_wvalue);
      if (sel[SelBadv])   badv_d   = masked_wr(badv_q, csr_wmask, csr_wvalue);
      if (sel[SelEentry]) eentry_d = masked_wr(eentry_q, csr_wmask & EentryWmask, csr_wvalue);
      if (sel[SelTid])    tid_d    = masked_wr(tid_q, csr_wmask, csr_wvalue);
      for (int i = 0; i < 4; i++) begin
        if (sel[int'(SelSave0) + i]) save_d[i] = masked_wr(save_q[i], csr_wmask, csr_wvalue);
      end
    end
  end

  // CSR state register; CRMD.DA comes out of reset set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crmd_q     <= 32'h0000_0001 << CrmdDaBit;
      prmd_q     <= '0;
      ecfg_q     <= '0;
      is_sw_q    <= '0;
      is_hw_q    <= '0;
      is_ipi_q   <= 1'b0;
      is_timer_q <= 1'b0;
      ecode_q    <= '0;
      esub_q     <= '0;
      era_q      <= '0;
      badv_q     <= '0;
      eentry_q   <= '0;
      for (int i = 0; i < 4; i++) save_q[i] <= '0;
      tid_q      <= TID_RESET;
    end else begin
      crmd_q     <= crmd_d;
      prmd_q     <= prmd_d;
      ecfg_q     <= ecfg_d;
      is_sw_q    <= is_sw_d;
      is_hw_q    <= hw_ext;
      is_ipi_q   <= ipi_int_in;
      is_timer_q <= is_timer_d;
      ecode_q    <= ecode_d;
      esub_q     <= esub_d;
      era_q      <= era_d;
      badv_q     <= badv_d;
      eentry_q   <= eentry_d;
      save_q     <= save_d;
      tid_q      <= tid_d;
    end
  end

  assign estat_is = {is_ipi_q, is_timer_q, 1'b0, is_hw_q, is_sw_q};
  assign estat_rd = {1'b0, esub_q, ecode_q, 3'b000, estat_is};

  // Per-select read data; TICLR always reads 0
  always_comb begin
    rd_data[SelCrmd]   = crmd_q;
    rd_data[SelPrmd]   = prmd_q;
    rd_data[SelEcfg]   = ecfg_q;
    rd_data[SelEstat]  = estat_rd;
    rd_data[SelEra]    = era_q;
    rd_data[SelBadv]   = badv_q;
    rd_data[SelEentry] = eentry_q;
    rd_data[SelSave0]  = save_q[0];
    rd_data[SelSave1]  = save_q[1];
    rd_data[SelSave2]  = save_q[2];
    rd_data[SelSave3]  = save_q[3];
    rd_data[SelTid]    = tid_q;
    rd_data[SelTcfg]   = tcfg_rd;
    rd_data[SelTval]   = tval_rd;
    rd_data[SelTiclr]  = '0;
  end

  // AND-OR read mux over the one-hot select
  always_comb begin
    csr_rvalue = '0;
    for (int i = 0; i < NumSel; i++) begin
      if (csr_re && sel[i]) csr_rvalue = csr_rvalue | rd_data[i];
    end
  end

  assign ex_entry = eentry_q;
  assign ertn_pc  = era_q;
  assign has_int  = (|(estat_is & ecfg_q[12:0])) & crmd_q[CrmdIeBit];

endmodule

// File: tb/tb_csr_unit_timer.sv
// Directed bench for csr_unit_timer: reset, masked writes, timer modes, exceptions, interrupts.
module tb_csr_unit_timer;
  import csr_unit_timer_pkg::*;

  logic        clk;
  logic        rst;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic [31:0] ex_entry;
  logic [31:0] ertn_pc;
  logic        has_int;

  int checks;
  int passes;

  csr_unit_timer #(
    .TIMER_W   (32),
    .HWI_NUM   (8),
    .TID_RESET (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_re      (csr_re),
    .csr_num     (csr_num),
    .csr_rvalue  (csr_rvalue),
    .csr_we      (csr_we),
    .csr_wmask   (csr_wmask),
    .csr_wvalue  (csr_wvalue),
    .hw_int_in   (hw_int_in),
    .ipi_int_in  (ipi_int_in),
    .wb_ex       (wb_ex),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .wb_pc       (wb_pc),
    .wb_vaddr    (wb_vaddr),
    .ertn_flush  (ertn_flush),
    .ex_entry    (ex_entry),
    .ertn_pc     (ertn_pc),
    .has_int     (has_int)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic rd(input logic [13:0] num, output logic [31:0] val);
    csr_re  = 1'b1;
    csr_num = num;
    #1;
    val     = csr_rvalue;
    csr_re  = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [13:0] num, input logic [31:0] exp);
    logic [31:0] v;
    rd(num, v);
    check(tag, v, exp);
  endtask

  // One-cycle CSR write; called at a negedge, returns at the next negedge
  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_we     = 1'b1;
    csr_num    = num;
    csr_wmask  = mask;
    csr_wvalue = val;
    @(negedge clk);
    csr_we     = 1'b0;
  endtask

  initial begin
    logic [13:0] zero_addrs [13];
    logic [31:0] v;
    checks      = 0;
    passes      = 0;
    rst         = 1'b1;
    csr_re      = 1'b0;
    csr_num     = '0;
    csr_we      = 1'b0;
    csr_wmask   = '0;
    csr_wvalue  = '0;
    hw_int_in   = '0;
    ipi_int_in  = 1'b0;
    wb_ex       = 1'b0;
    wb_ecode    = '0;
    wb_esubcode = '0;
    wb_pc       = '0;
    wb_vaddr    = '0;
    ertn_flush  = 1'b0;
    zero_addrs  = '{CsrPrmd, CsrEcfg, CsrEstat, CsrEra, CsrBadv, CsrEentry, CsrSave0, CsrSave1,
                    CsrSave2, CsrSave3, CsrTid, CsrTcfg, CsrTval};
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_rd("rst_crmd", CsrCrmd, 32'h8);
    foreach (zero_addrs[i]) check_rd($sformatf("rst_csr_%0h", zero_addrs[i]), zero_addrs[i], 0);
    check("rst_has_int", {31'b0, has_int}, 0);
    check("rst_ex_entry", ex_entry, 0);
    check("rst_ertn_pc", ertn_pc, 0);
    @(negedge clk);

    // Masked writes, unimplemented address, read-enable gating
    wr(CsrSave0, 32'hffff_0000, 32'haaaa_aaaa);
    check_rd("save0_hi", CsrSave0, 32'haaaa_0000);
    wr(CsrSave0, 32'h0000_ffff, 32'h1234_5678);
    check_rd("save0_lo", CsrSave0, 32'haaaa_5678);
    wr(CsrTid, 32'hffff_ffff, 32'h55);
    check_rd("tid_wr", CsrTid, 32'h55);
    check_rd("unimpl_rd", 14'h003, 0);
    csr_re = 1'b0; csr_num = CsrSave0; #1;
    check("re_low", csr_rvalue, 0);
    wr(CsrEentry, 32'hffff_ffff, 32'h1c00_8fff);
    check_rd("eentry_rd", CsrEentry, 32'h1c00_8fc0);
    check("ex_entry", ex_entry, 32'h1c00_8fc0);

    // One-shot timer, InitVal 5
    wr(CsrTcfg, 32'hffff_ffff, 32'h15);
    check_rd("os_tval20", CsrTval, 32'd20);
    repeat (19) @(negedge clk);
    check_rd("os_tval1", CsrTval, 32'd1);
    check_rd("os_is11_pre", CsrEstat, 0);
    @(negedge clk);
    check_rd("os_tval0", CsrTval, 0);
    check_rd("os_is11_fire", CsrEstat, 32'h800);
    repeat (3) @(negedge clk);
    check_rd("os_hold0", CsrTval, 0);
    wr(CsrTiclr, 32'h1, 32'h1);
    check_rd("os_ticlr", CsrEstat, 0);
    check_rd("ticlr_rd0", CsrTiclr, 0);

    // Periodic timer, InitVal 1: fires every 5 cycles
    wr(CsrTcfg, 32'hffff_ffff, 32'h7);
    check_rd("per_tval4", CsrTval, 32'd4);
    repeat (3) @(negedge clk);
    check_rd("per_tval1", CsrTval, 32'd1);
    @(negedge clk);
    check_rd("per_fire1", CsrEstat, 32'h800);
    wr(CsrTiclr, 32'h1, 32'h1);
    check_rd("per_reload", CsrTval, 32'd4);
    check_rd("per_clr", CsrEstat, 0);
    repeat (3) @(negedge clk);
    wr(CsrTiclr, 32'h1, 32'h1);  // lands on the fire edge
    check_rd("per_fire_clr", CsrEstat, 32'h800);
    wr(CsrTiclr, 32'h1, 32'h1);
    check_rd("per_clr2", CsrEstat, 0);

    // Timer interrupt reaches has_int
    wr(CsrCrmd, 32'h4, 32'h4);
    check_rd("crmd_ie", CsrCrmd, 32'hc);
    wr(CsrEcfg, 32'hffff_ffff, 32'h800);
    @(negedge clk);
    check("hi_pre", {31'b0, has_int}, 0);
    @(negedge clk);
    check("hi_fire", {31'b0, has_int}, 1);
    wr(CsrTcfg, 32'hffff_ffff, 32'h0);
    wr(CsrTiclr, 32'h1, 32'h1);
    check("hi_clr", {31'b0, has_int}, 0);
    wr(CsrEcfg, 32'hffff_ffff, 32'h400);
    check_rd("ecfg_bit10", CsrEcfg, 0);

    // En=0 freezes TVAL; periodic InitVal 0 never fires
    wr(CsrTcfg, 32'hffff_ffff, 32'h14);
    repeat (3) @(negedge clk);
    check_rd("frz_tval", CsrTval, 32'd20);
    check_rd("frz_tcfg", CsrTcfg, 32'h14);
    wr(CsrTcfg, 32'hffff_ffff, 32'h3);
    repeat (6) @(negedge clk);
    check_rd("iv0_estat", CsrEstat, 0);
    wr(CsrTcfg, 32'hffff_ffff, 32'h0);

    // Exception with ALE and a colliding ERA write
    wr(CsrCrmd, 32'h3, 32'h3);
    check_rd("crmd_plv3", CsrCrmd, 32'hf);
    wb_ex = 1'b1; wb_ecode = 6'h09; wb_esubcode = 9'h0;
    wb_pc = 32'h1c00_0100; wb_vaddr = 32'h1234_5673;
    wr(CsrEra, 32'hffff_ffff, 32'hdead_beef);
    wb_ex = 1'b0;
    check_rd("ex_era", CsrEra, 32'h1c00_0100);
    check_rd("ex_badv", CsrBadv, 32'h1234_5673);
    check_rd("ex_crmd", CsrCrmd, 32'h8);
    check_rd("ex_prmd", CsrPrmd, 32'h7);
    check_rd("ex_estat", CsrEstat, 32'h0009_0000);
    check("ex_ertn_pc", ertn_pc, 32'h1c00_0100);
    ertn_flush = 1'b1;
    @(negedge clk);
    ertn_flush = 1'b0;
    check_rd("ertn_crmd", CsrCrmd, 32'hf);

    // Non-address exception leaves BADV alone
    wb_ex = 1'b1; wb_ecode = 6'h01; wb_esubcode = 9'h1;
    wb_pc = 32'h1c00_0200; wb_vaddr = 32'hffff_ffff;
    @(negedge clk);
    wb_ex = 1'b0;
    check_rd("ex2_badv", CsrBadv, 32'h1234_5673);
    check_rd("ex2_estat", CsrEstat, 32'h0041_0000);
    check_rd("ex2_era", CsrEra, 32'h1c00_0200);

    // Software IS bits and IE gating of has_int
    wr(CsrEstat, 32'hffff_ffff, 32'hffff_ffff);
    check_rd("estat_sw", CsrEstat, 32'h0041_0003);
    wr(CsrEcfg, 32'hffff_ffff, 32'h3);
    check("sw_ie0", {31'b0, has_int}, 0);
    ertn_flush = 1'b1;
    @(negedge clk);
    ertn_flush = 1'b0;
    check("sw_ie1", {31'b0, has_int}, 1);
    wr(CsrEcfg, 32'hffff_ffff, 32'h0);

    // hw_int_in[0] and ipi pulses show up one cycle later for one cycle
    hw_int_in = 8'h01;
    rd(CsrEstat, v); check("is2_pre", {31'b0, v[2]}, 0);
    @(negedge clk);
    rd(CsrEstat, v); check("is2_hi", {31'b0, v[2]}, 1);
    hw_int_in = 8'h00;
    @(negedge clk);
    rd(CsrEstat, v); check("is2_lo", {31'b0, v[2]}, 0);
    ipi_int_in = 1'b1;
    @(negedge clk);
    ipi_int_in = 1'b0;
    rd(CsrEstat, v); check("is12_hi", {31'b0, v[12]}, 1);
    @(negedge clk);
    rd(CsrEstat, v); check("is12_lo", {31'b0, v[12]}, 0);

    // Asynchronous reset mid-count
    wr(CsrTcfg, 32'hffff_ffff, 32'h15);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    check_rd("arst_tval", CsrTval, 0);
    check_rd("arst_tcfg", CsrTcfg, 0);
    check_rd("arst_crmd", CsrCrmd, 32'h8);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_rd("post_rst_tval", CsrTval, 0);
    check_rd("post_rst_estat", CsrEstat, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
